sound_mixer_nch: RTL and testbench

//  Parametrised N-channel stereo output mixer for the sound subsystem. Generates its own sample tick

---
 rtl/sound_mixer_nch.sv | 126 ++++++++++++
 tb/tb_sound_mixer_nch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_mixer_nch.sv
// sound_mixer_nch: N-channel stereo mixer with per-channel/master shift volume, ramping, saturation
module sound_mixer_nch #(
  parameter int NCH = 4,
  parameter int IW = 16,
  parameter int OW = 16,
  parameter int SAMPLE_HZ = 48000,
  parameter int RAMP = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [27:0]           clock_rate,
  input  logic [NCH*IW-1:0]     ch_l,
  input  logic [NCH*IW-1:0]     ch_r,
  input  logic [NCH*5-1:0]      vol_l,
  input  logic [NCH*5-1:0]      vol_r,
  input  logic [NCH-1:0]        mute,
  input  logic [4:0]            master_l,
  input  logic [4:0]            master_r,
  input  logic                  clip_clr,
  output logic signed [OW-1:0]  out_l,
  output logic signed [OW-1:0]  out_r,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  clip_l,
  output logic                  clip_r,
  output logic                  overrun
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int AW = IW + $clog2(NCH) + 1;
  localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, CAPT, ACC, MAST} state_t;
  state_t state, state_nx;
  logic [27:0] cr_q;
  logic [31:0] sum, sum_add;
  logic tick;
  logic signed [IW-1:0] sl [NCH];
  logic signed [IW-1:0] sr [NCH];
  logic [4:0] el [NCH];
  logic [4:0] er [NCH];
  logic [NCH-1:0] mute_q;
  logic [4:0] ml, mr;
  logic [CW-1:0] idx;
  logic signed [AW-1:0] acc_l, acc_r, add_l, add_r, m_l, m_r;
  logic signed [OW-1:0] res_l, res_r;
  logic sat_l, sat_r;
  function automatic logic signed [AW-1:0] vol(input logic signed [AW-1:0] x, input logic [4:0] v);
    if (v == 5'd0) return '0;
    return x >>> (4'hF ^ v[4:1]);
  endfunction
  function automatic logic [4:0] step(input logic [4:0] c, input logic [4:0] t);
    return c < t ? c + 5'd1 : c > t ? c - 5'd1 : c;
  endfunction
  assign sum_add = sum + 32'(SAMPLE_HZ);
  assign tick = cr_q != '0 && sum_add >= 32'(cr_q);
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (tick ? CAPT : IDLE) :
               state == CAPT ? ACC :
               state == ACC ? (idx == CW'(NCH-1) ? MAST : ACC) : IDLE;
    add_l = mute_q[idx] ? '0 : vol(AW'(sl[idx]), el[idx]);
    add_r = mute_q[idx] ? '0 : vol(AW'(sr[idx]), er[idx]);
    m_l = vol(acc_l, ml);
    m_r = vol(acc_r, mr);
    sat_l = m_l > MAXV || m_l < MINV;
    sat_r = m_r > MAXV || m_r < MINV;
    res_l = m_l > MAXV ? MAXV[OW-1:0] : m_l < MINV ? MINV[OW-1:0] : m_l[OW-1:0];
    res_r = m_r > MAXV ? MAXV[OW-1:0] : m_r < MINV ? MINV[OW-1:0] : m_r[OW-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cr_q <= '0;
      sum <= '0;
      idx <= '0;
      acc_l <= '0;
      acc_r <= '0;
      mute_q <= '0;
      ml <= '0;
      mr <= '0;
      out_l <= '0;
      out_r <= '0;
      out_valid <= 1'b0;
      clip_l <= 1'b0;
      clip_r <= 1'b0;
      overrun <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        sl[k] <= '0;
        sr[k] <= '0;
        el[k] <= '0;
        er[k] <= '0;
      end
    end else begin
      state <= state_nx;
      cr_q <= clock_rate;
      sum <= tick ? sum_add - 32'(cr_q) : cr_q != '0 ? sum_add : sum;
      out_valid <= state == MAST;
      overrun <= !clip_clr && (overrun || (tick && state != IDLE));
      clip_l <= !clip_clr && (clip_l || (state == MAST && sat_l));
      clip_r <= !clip_clr && (clip_r || (state == MAST && sat_r));
      if (state == CAPT) begin
        for (int k = 0; k < NCH; k++) begin
          sl[k] <= ch_l[k*IW +: IW];
          sr[k] <= ch_r[k*IW +: IW];
          el[k] <= RAMP == 0 ? vol_l[k*5 +: 5] : step(el[k], vol_l[k*5 +: 5]);
          er[k] <= RAMP == 0 ? vol_r[k*5 +: 5] : step(er[k], vol_r[k*5 +: 5]);
        end
        mute_q <= mute;
        ml <= master_l;
        mr <= master_r;
        acc_l <= '0;
        acc_r <= '0;
        idx <= '0;
      end
      if (state == ACC) begin
        acc_l <= acc_l + add_l;
        acc_r <= acc_r + add_r;
        idx <= idx + 1'b1;
      end
      if (state == MAST) begin
        out_l <= res_l;
        out_r <= res_r;
      end
    end
  end
endmodule

// File: tb/tb_sound_mixer_nch.sv
// tb_sound_mixer_nch: scoreboard bench for sound_mixer_nch with RAMP=0 and RAMP=1 instances
module tb_sound_mixer_nch;
  localparam int NCH = 4;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int LAT = NCH + 2;
  typedef struct {int l; int r; bit cl; bit cr;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [27:0] clock_rate;
  logic [NCH*IW-1:0] ch_l, ch_r;
  logic [NCH*5-1:0] vol_l, vol_r;
  logic [NCH-1:0] mute;
  logic [4:0] master_l, master_r;
  logic clip_clr;
  logic signed [OW-1:0] out_l [2];
  logic signed [OW-1:0] out_r [2];
  logic out_valid [2];
  logic busy [2];
  logic clip_l [2];
  logic clip_r [2];
  logic overrun [2];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tl [NCH];
  int tr [NCH];
  int vl [NCH];
  int vr [NCH];
  bit mu [NCH];
  int ml, mr;
  int el [2][NCH];
  int er [2][NCH];
  bit cl_exp [2];
  bit cr_exp [2];
  exp_t sbq [2][$];
  bit sb_on = 1'b0;
  bit ramp_phase = 1'b0;
  int trise [2] = '{-1, -1};
  bit bprev [2] = '{1'b0, 1'b0};
  int lastov = -1;
  int prev1 = -1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sound_mixer_nch #(.NCH(NCH), .IW(IW), .OW(OW), .SAMPLE_HZ(48000), .RAMP(0)) u0 (
    .clk(clk), .rst(rst), .clock_rate(clock_rate), .ch_l(ch_l), .ch_r(ch_r),
    .vol_l(vol_l), .vol_r(vol_r), .mute(mute), .master_l(master_l), .master_r(master_r),
    .clip_clr(clip_clr), .out_l(out_l[0]), .out_r(out_r[0]), .out_valid(out_valid[0]),
    .busy(busy[0]), .clip_l(clip_l[0]), .clip_r(clip_r[0]), .overrun(overrun[0]));
  sound_mixer_nch #(.NCH(NCH), .IW(IW), .OW(OW), .SAMPLE_HZ(48000), .RAMP(1)) u1 (
    .clk(clk), .rst(rst), .clock_rate(clock_rate), .ch_l(ch_l), .ch_r(ch_r),
    .vol_l(vol_l), .vol_r(vol_r), .mute(mute), .master_l(master_l), .master_r(master_r),
    .clip_clr(clip_clr), .out_l(out_l[1]), .out_r(out_r[1]), .out_valid(out_valid[1]),
    .busy(busy[1]), .clip_l(clip_l[1]), .clip_r(clip_r[1]), .overrun(overrun[1]));
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // x scaled by 2^-(15 - v/2), rounded toward minus infinity
  function automatic longint vf(input longint x, input int v);
    longint d, q;
    if (v == 0) return 0;
    d = longint'(1) << (15 - v / 2);
    q = x / d;
    if (x < 0 && q * d != x) q = q - 1;
    return q;
  endfunction
  function automatic int satv(input longint m, output bit c);
    c = m > 32767 || m < -32768;
    return m > 32767 ? 32767 : m < -32768 ? -32768 : int'(m);
  endfunction
  function automatic int rnd_s();
    if ($urandom_range(0, 5) == 0) return $urandom_range(0, 1) == 1 ? 32767 : -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction
  task automatic drive(input bit clr);
    for (int k = 0; k < NCH; k++) begin
      ch_l[k*IW +: IW] = 16'(tl[k]);
      ch_r[k*IW +: IW] = 16'(tr[k]);
      vol_l[k*5 +: 5] = 5'(vl[k]);
      vol_r[k*5 +: 5] = 5'(vr[k]);
      mute[k] = mu[k];
    end
    master_l = 5'(ml);
    master_r = 5'(mr);
    clip_clr = clr;
  endtask
  task automatic push_expect(input bit clr);
    exp_t e;
    longint al, ar;
    bit sl, sr;
    drive(clr);
    for (int u = 0; u < 2; u++) begin
      al = 0;
      ar = 0;
      for (int k = 0; k < NCH; k++) begin
        if (u == 0) begin
          el[u][k] = vl[k];
          er[u][k] = vr[k];
        end else begin
          el[u][k] += (el[u][k] < vl[k]) ? 1 : (el[u][k] > vl[k]) ? -1 : 0;
          er[u][k] += (er[u][k] < vr[k]) ? 1 : (er[u][k] > vr[k]) ? -1 : 0;
        end
        if (!mu[k]) begin
          al += vf(tl[k], el[u][k]);
          ar += vf(tr[k], er[u][k]);
        end
      end
      e.l = satv(vf(al, ml), sl);
      e.r = satv(vf(ar, mr), sr);
      cl_exp[u] = !clr && (cl_exp[u] || sl);
      cr_exp[u] = !clr && (cr_exp[u] || sr);
      e.cl = cl_exp[u];
      e.cr = cr_exp[u];
      sbq[u].push_back(e);
    end
  endtask
  task automatic wait_ov();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[0] && n < 100);
    if (!out_valid[0]) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_out_valid: no pulse within 100 cycles (cycle %0d)", cyc);
    end
  endtask
  task automatic step(input bit clr);
    wait_ov();
    push_expect(clr);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && !bprev[i]) trise[i] = cyc;
      if (out_valid[i]) begin
        chk($sformatf("latency%0d", i), cyc - trise[i], LAT);
        if (sb_on) begin
          if (sbq[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard%0d: unexpected out_valid, queue empty (cycle %0d)", i, cyc);
          end else begin
            exp_t e;
            e = sbq[i].pop_front();
            chk($sformatf("out_l%0d", i), out_l[i], e.l);
            chk($sformatf("out_r%0d", i), out_r[i], e.r);
            chk($sformatf("clip_l%0d", i), clip_l[i], e.cl);
            chk($sformatf("clip_r%0d", i), clip_r[i], e.cr);
            chk($sformatf("overrun%0d", i), overrun[i], 0);
          end
          if (i == 0) begin
            if (lastov >= 0) chk("tick_period", cyc - lastov, 10);
            lastov = cyc;
          end
          if (i == 1 && ramp_phase) begin
            chk("ramp_monotonic", int'(out_l[1]) >= prev1, 1);
            prev1 = out_l[1];
          end
        end
      end
      bprev[i] = busy[i];
    end
  end
  initial begin
    int n;
    clock_rate = 28'd480000;
    for (int k = 0; k < NCH; k++) begin
      tl[k] = 0;
      tr[k] = 0;
      vl[k] = 31;
      vr[k] = 31;
      mu[k] = 1'b0;
      for (int u = 0; u < 2; u++) begin
        el[u][k] = 0;
        er[u][k] = 0;
      end
    end
    cl_exp = '{1'b0, 1'b0};
    cr_exp = '{1'b0, 1'b0};
    tl[0] = 16384;
    ml = 31;
    mr = 31;
    sb_on = 1'b1;
    ramp_phase = 1'b1;
    push_expect(1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out_l%0d", i), out_l[i], 0);
      chk($sformatf("rst_out_r%0d", i), out_r[i], 0);
      chk($sformatf("rst_valid%0d", i), out_valid[i], 0);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_clip_l%0d", i), clip_l[i], 0);
      chk($sformatf("rst_clip_r%0d", i), clip_r[i], 0);
      chk($sformatf("rst_overrun%0d", i), overrun[i], 0);
    end
    rst = 1'b0;
    repeat (33) step(1'b0);
    ramp_phase = 1'b0;
    tl[0] = 1000;
    step(1'b0);
    tl[1] = 1000;
    vl[1] = 29;
    step(1'b0);
    for (int k = 0; k < NCH; k++) begin
      tl[k] = 32767;
      vl[k] = 31;
    end
    step(1'b0);
    step(1'b1);
    for (int k = 0; k < NCH; k++) tl[k] = 0;
    step(1'b0);
    repeat (60) begin
      for (int k = 0; k < NCH; k++) begin
        tl[k] = rnd_s();
        tr[k] = rnd_s();
        vl[k] = $urandom_range(0, 31);
        vr[k] = $urandom_range(0, 31);
        mu[k] = $urandom_range(0, 3) == 0;
      end
      ml = $urandom_range(16, 31);
      mr = $urandom_range(16, 31);
      step($urandom_range(0, 7) == 0);
    end
    wait_ov();
    @(posedge clk);
    sb_on = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      tl[k] = 0;
      tr[k] = 0;
      vl[k] = 31;
      vr[k] = 31;
      mu[k] = 1'b0;
    end
    tl[0] = 1234;
    ml = 31;
    mr = 31;
    @(negedge clk);
    drive(1'b0);
    clock_rate = 28'd192000;
    repeat (200) @(negedge clk);
    chk("overrun_set0", overrun[0], 1);
    chk("overrun_set1", overrun[1], 1);
    chk("overrun_out_l0", out_l[0], 1234);
    clip_clr = 1'b1;
    @(negedge clk);
    chk("overrun_clr0", overrun[0], 0);
    chk("overrun_clr1", overrun[1], 0);
    clip_clr = 1'b0;
    clock_rate = 28'd480000;
    n = 0;
    while (busy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (!busy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_busy_seen", busy[0], 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("abort_out_l%0d", i), out_l[i], 0);
        chk($sformatf("abort_valid%0d", i), out_valid[i], 0);
        chk($sformatf("abort_busy%0d", i), busy[i], 0);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < NCH; k++)
      for (int u = 0; u < 2; u++) begin
        el[u][k] = 0;
        er[u][k] = 0;
      end
    cl_exp = '{1'b0, 1'b0};
    cr_exp = '{1'b0, 1'b0};
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_pulse0", out_valid[0], 0);
      chk("abort_no_pulse1", out_valid[1], 0);
    end
    lastov = -1;
    sb_on = 1'b1;
    push_expect(1'b0);
    repeat (3) step(1'b0);
    wait_ov();
    repeat (2) @(negedge clk);
    chk("queue_drained0", sbq[0].size(), 0);
    chk("queue_drained1", sbq[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
